// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-port bundle between a byte FIFO and the fifo_uart_tx serialiser.
//   empty : FIFO empty flag (FIFO -> consumer)
//   din   : FIFO read data, valid the cycle after rd (FIFO -> consumer)
//   rd    : single-cycle pop strobe (consumer -> FIFO)
// Modports:
//   master : the consumer that issues pops (fifo_uart_tx)
//   slave  : the FIFO that answers them
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if;
    logic       empty;
    logic [7:0] din;
    logic       rd;

    modport master (
        input  empty,
        input  din,
        output rd
    );

    modport slave (
        output empty,
        output din,
        input  rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from a FIFO (one rd strobe per byte) and serialises each one as
// an asynchronous UART frame: start bit, 8 data bits LSB first, optional even
// parity bit, STOP_BITS stop bits.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent between the data and stop bits
//   undefined -> no parity state or logic
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//   STOP_BITS    : 1 or 2
// Ports:
//   clk   : system clock, posedge
//   rst   : synchronous active-high reset
//   en    : fetch enable, only gates the start of a new frame
//   fifo  : FIFO read port (empty, din in; rd out)
//   tx    : serial line, idle high
//   busy  : high whenever the FSM is not idle
//   done  : one-cycle pulse in the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rd_q, rd_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            rd_q       <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state logic. The bit timer is cleared on every bit boundary and
    // held at zero in the untimed states, so each timed state starts at 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        bit_end    = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                stop_idx_d = 1'b0;
                if (en && !fifo.empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // din is valid now, one cycle after the pop strobe.
                cnt_d   = '0;
                shreg_d = fifo.din;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo.din;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each
    // registered output lines up exactly with the state it describes.
    always_comb begin
        rd_d   = (state_d == S_FETCH);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) &&
                 (stop_idx_d == STOP_LAST);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign fifo.rd = rd_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
